nios_system_onchip_memory_pipelined: RTL and testbench

//  Parametrised Avalon-MM on-chip RAM slave, successor to the fixed 2048x32 single-port RAM.

---
 rtl/nios_system_mem_pkg.sv | 27 ++
 rtl/nios_system_onchip_memory_pipelined_if.sv | 30 +++
 rtl/nios_system_ram_sp.sv | 39 +++
 rtl/nios_system_onchip_memory_pipelined.sv | 159 +++++++++++++++
 tb/tb_nios_system_onchip_memory_pipelined.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nios_system_mem_pkg.sv
// Shared definitions for the Avalon-MM on-chip RAM slave: FSM states,
// legal read-latency range and a constant clog2 helper.
package nios_system_mem_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } mem_state_t;

  localparam int MIN_RD_LAT = 1;
  localparam int MAX_RD_LAT = 2;

  // Bits needed to index 'value' entries; 0 for value <= 1.
  function automatic int clog2(input int unsigned value);
    int          result;
    int unsigned v;
    result = 0;
    v      = (value > 0) ? value - 1 : 0;
    for (int i = 0; i < 32; i++) begin
      if ((v >> i) != 0) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/nios_system_onchip_memory_pipelined_if.sv
// Avalon-MM slave bus bundle for the pipelined on-chip RAM, including the
// clock-enable and init_done sideband signals.
interface nios_system_onchip_memory_pipelined_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
) ();

  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic                    chipselect;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH-1:0]   writedata;
  logic                    clken;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;
  logic                    waitrequest;
  logic                    init_done;

  modport master (
    output address, byteenable, chipselect, read, write, writedata, clken,
    input  readdata, readdatavalid, waitrequest, init_done
  );

  modport slave (
    input  address, byteenable, chipselect, read, write, writedata, clken,
    output readdata, readdatavalid, waitrequest, init_done
  );

endinterface

// File: rtl/nios_system_ram_sp.sv
// Behavioural single-port RAM with per-byte write enables and a registered
// read port; the arrays carry no reset so they map onto block RAM.
module nios_system_ram_sp #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2048,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic                    re,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int NUM_LANES = DATA_WIDTH / 8;

  // One narrow array per byte lane keeps every lane a simple write-enabled RAM.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rdata_reg;

      always_ff @(posedge clk) begin
        if (we && be[gi]) begin
          mem[addr] <= wdata[gi*8 +: 8];
        end
        if (re) begin
          rdata_reg <= mem[addr];
        end
      end

      assign rdata[gi*8 +: 8] = rdata_reg;
    end
  endgenerate

endmodule

// File: rtl/nios_system_onchip_memory_pipelined.sv
// Parametrised Avalon-MM on-chip RAM slave: optional zero-clear after reset,
// 1- or 2-cycle pipelined reads with readdatavalid, and clken freeze.
module nios_system_onchip_memory_pipelined
  import nios_system_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 2048,
  parameter int ADDR_WIDTH     = 11,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic clk,
  input logic reset_n,
  nios_system_onchip_memory_pipelined_if.slave bus
);

  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int RAM_AW    = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
  localparam logic [RAM_AW-1:0] LAST_ADDR = RAM_AW'(DEPTH - 1);
  localparam mem_state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  generate
    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8 || DATA_WIDTH > 128) begin : g_bad_width
      $error("DATA_WIDTH must be a multiple of 8 between 8 and 128");
    end
    if (READ_LATENCY < MIN_RD_LAT || READ_LATENCY > MAX_RD_LAT) begin : g_bad_latency
      $error("READ_LATENCY must be 1 or 2");
    end
    if ((64'd1 << ADDR_WIDTH) < 64'(DEPTH)) begin : g_bad_depth
      $error("ADDR_WIDTH too narrow to address DEPTH words");
    end
  endgenerate

  mem_state_t               state_reg;
  logic                     init_done_reg;
  logic [RAM_AW-1:0]        clr_cnt_reg;
  logic [READ_LATENCY-1:0]  vld_reg;
  logic                     zero_reg;

  logic                     waitrequest;
  logic                     in_range;
  logic                     rd_accept;
  logic                     wr_accept;
  logic                     ram_we;
  logic                     ram_re;
  logic [RAM_AW-1:0]        ram_addr;
  logic [NUM_LANES-1:0]     ram_be;
  logic [DATA_WIDTH-1:0]    ram_wdata;
  logic [DATA_WIDTH-1:0]    ram_rdata;
  logic [DATA_WIDTH-1:0]    ram_dout;

  // Request decode; a combined read+write is treated as a write only.
  assign waitrequest = (state_reg != ST_READY) | ~bus.clken;
  assign in_range    = (32'(bus.address) < 32'(DEPTH));
  assign wr_accept   = bus.chipselect & bus.write & ~waitrequest;
  assign rd_accept   = bus.chipselect & bus.read & ~bus.write & ~waitrequest;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= RESET_STATE;
      init_done_reg <= 1'b0;
      clr_cnt_reg   <= '0;
    end else begin
      case (state_reg)
        ST_CLEAR: begin
          if (bus.clken) begin
            if (clr_cnt_reg == LAST_ADDR) begin
              state_reg     <= ST_READY;
              init_done_reg <= 1'b1;
            end
            clr_cnt_reg <= clr_cnt_reg + RAM_AW'(1);
          end
        end
        ST_READY: begin
          init_done_reg <= 1'b1;
        end
        default: begin
          state_reg <= RESET_STATE;
        end
      endcase
    end
  end

  // The clear sweep owns the RAM port until READY; out-of-range requests
  // are steered to word 0 and never write.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_be    = '0;
    ram_wdata = '0;
    if (state_reg == ST_CLEAR) begin
      ram_we   = bus.clken;
      ram_addr = clr_cnt_reg;
      ram_be   = '1;
    end else begin
      ram_we    = wr_accept & in_range;
      ram_addr  = in_range ? bus.address[RAM_AW-1:0] : '0;
      ram_be    = bus.byteenable;
      ram_wdata = bus.writedata;
    end
  end

  assign ram_re = rd_accept;

  nios_system_ram_sp #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .be    (ram_be),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // zero_reg travels with the RAM output register: it forces out-of-range
  // reads to 0 and makes readdata read 0 straight after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_reg  <= '0;
      zero_reg <= 1'b1;
    end else if (bus.clken) begin
      vld_reg <= READ_LATENCY'({vld_reg, rd_accept});
      if (rd_accept) begin
        zero_reg <= ~in_range;
      end
    end
  end

  assign ram_dout = zero_reg ? '0 : ram_rdata;

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] rdata2_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          rdata2_reg <= '0;
        end else if (bus.clken && vld_reg[0]) begin
          rdata2_reg <= ram_dout;
        end
      end

      assign bus.readdata = rdata2_reg;
    end else begin : g_lat1
      assign bus.readdata = ram_dout;
    end
  endgenerate

  // A frozen pipeline keeps its pending valid; masking it with clken makes the
  // pulse appear exactly once, in the first active cycle.
  assign bus.readdatavalid = vld_reg[READ_LATENCY-1] & bus.clken;
  assign bus.waitrequest   = waitrequest;
  assign bus.init_done     = init_done_reg;

endmodule

// File: tb/tb_nios_system_onchip_memory_pipelined.sv
// Bench for the pipelined on-chip RAM: three instances (16 words latency 1,
// 16 words latency 2, 12 words latency 1) share one stimulus stream.
module tb_nios_system_onchip_memory_pipelined;

  localparam int NI = 3;
  localparam int DEP [NI] = '{16, 16, 12};
  localparam int LAT [NI] = '{1, 2, 1};

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] cyc;
  } sb_t;

  typedef struct packed {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp16;
    logic [31:0] exp12;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  address;
  logic [3:0]  byteenable;
  logic        chipselect;
  logic        read;
  logic        write;
  logic        clken;
  logic [31:0] writedata;

  int          errors = 0;
  int          checks = 0;
  int unsigned act_cnt = 0;
  sb_t         q0[$];
  sb_t         q1[$];
  sb_t         q2[$];
  vec_t        vecs [22];

  always #5 clk = ~clk;

  nios_system_onchip_memory_pipelined_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus0 ();
  nios_system_onchip_memory_pipelined_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus1 ();
  nios_system_onchip_memory_pipelined_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus2 ();

  assign bus0.address = address;    assign bus1.address = address;    assign bus2.address = address;
  assign bus0.byteenable = byteenable; assign bus1.byteenable = byteenable; assign bus2.byteenable = byteenable;
  assign bus0.chipselect = chipselect; assign bus1.chipselect = chipselect; assign bus2.chipselect = chipselect;
  assign bus0.read = read;          assign bus1.read = read;          assign bus2.read = read;
  assign bus0.write = write;        assign bus1.write = write;        assign bus2.write = write;
  assign bus0.writedata = writedata; assign bus1.writedata = writedata; assign bus2.writedata = writedata;
  assign bus0.clken = clken;        assign bus1.clken = clken;        assign bus2.clken = clken;

  nios_system_onchip_memory_pipelined #(
    .DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(4), .READ_LATENCY(1), .CLEAR_ON_RESET(1)
  ) u_lat1 (.clk(clk), .reset_n(reset_n), .bus(bus0));

  nios_system_onchip_memory_pipelined #(
    .DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(4), .READ_LATENCY(2), .CLEAR_ON_RESET(1)
  ) u_lat2 (.clk(clk), .reset_n(reset_n), .bus(bus1));

  nios_system_onchip_memory_pipelined #(
    .DATA_WIDTH(32), .DEPTH(12), .ADDR_WIDTH(4), .READ_LATENCY(1), .CLEAR_ON_RESET(1)
  ) u_d12 (.clk(clk), .reset_n(reset_n), .bus(bus2));

  logic [NI-1:0] rdv;
  logic [NI-1:0] wreq;
  logic [NI-1:0] idone;
  logic [31:0]   rdat [NI];

  assign rdv   = {bus2.readdatavalid, bus1.readdatavalid, bus0.readdatavalid};
  assign wreq  = {bus2.waitrequest, bus1.waitrequest, bus0.waitrequest};
  assign idone = {bus2.init_done, bus1.init_done, bus0.init_done};
  assign rdat[0] = bus0.readdata;
  assign rdat[1] = bus1.readdata;
  assign rdat[2] = bus2.readdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input int i, input logic [31:0] d, input logic [31:0] cyc);
    sb_t e;
    e.data = d;
    e.cyc  = cyc;
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop(input int i, output bit ok, output sb_t e);
    ok = 1'b0;
    e  = '0;
    case (i)
      0:       if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
      1:       if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  // Every valid pulse must match the oldest expectation in data and in active-cycle count.
  task automatic monitor();
    sb_t e;
    bit  ok;
    for (int i = 0; i < NI; i++) begin
      if (rdv[i]) begin
        pop(i, ok, e);
        if (!ok) begin
          chk($sformatf("spurious_valid_u%0d", i), 32'(rdv[i]), 32'd0);
        end else begin
          $display("read u%0d data=0x%08h expected=0x%08h cycle=%0d", i, rdat[i], e.data, act_cnt);
          chk($sformatf("rdata_u%0d", i), rdat[i], e.data);
          chk($sformatf("latency_u%0d", i), act_cnt, e.cyc);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (clken) act_cnt++;
    @(negedge clk);
    monitor();
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
  endtask

  task automatic issue(input logic wr, input logic rd, input logic [3:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    chk("req_not_stalled", 32'(wreq), 32'd0);
    chipselect = 1'b1;
    write      = wr;
    read       = rd;
    address    = a;
    writedata  = d;
    byteenable = be;
    tick();
    chipselect = 1'b0;
    write      = 1'b0;
    read       = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a, input logic [31:0] e16, input logic [31:0] e12);
    for (int i = 0; i < NI; i++) begin
      push(i, (DEP[i] == 12) ? e12 : e16, act_cnt + 32'(LAT[i]));
    end
    issue(1'b0, 1'b1, a, 32'd0, 4'd0);
  endtask

  task automatic check_sb_empty(input string tag);
    chk({"sb_empty_", tag}, 32'(q0.size() + q1.size() + q2.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(rdv), 32'd0);
    chk({tag, "_init_done"}, 32'(idone), 32'd0);
    chk({tag, "_waitreq"}, 32'(wreq), 32'd7);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s_rdata_u%0d", tag, i), rdat[i], 32'd0);
    end
  endtask

  // Call right after reset release: each instance stalls for exactly DEPTH cycles.
  task automatic check_clear();
    for (int c = 0; c < 16; c++) begin
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("clear_wait_u%0d_c%0d", i, c), 32'(wreq[i]), 32'(c < DEP[i]));
        chk($sformatf("clear_done_u%0d_c%0d", i, c), 32'(idone[i]), 32'(c >= DEP[i]));
      end
      tick();
    end
    chk("clear_end_waitreq", 32'(wreq), 32'd0);
    chk("clear_end_init_done", 32'(idone), 32'd7);
  endtask

  task automatic read_all_zero();
    for (int a = 0; a < 16; a++) begin
      do_read(4'(a), 32'd0, 32'd0);
    end
    drain(4);
    check_sb_empty("zero_sweep");
  endtask

  initial begin
    chipselect = 1'b0; read = 1'b0; write = 1'b0; address = '0;
    writedata = '0; byteenable = '0; clken = 1'b1; reset_n = 1'b0;

    //            wr    addr   data          be       exp (16 deep)  exp (12 deep)
    vecs[0]  = '{1'b1, 4'd5,  32'hDEADBEEF, 4'b0101, 32'h0,        32'h0};
    vecs[1]  = '{1'b0, 4'd5,  32'h0,        4'b0000, 32'h00AD00EF, 32'h00AD00EF};
    vecs[2]  = '{1'b1, 4'd0,  32'h00000010, 4'b1111, 32'h0,        32'h0};
    vecs[3]  = '{1'b1, 4'd1,  32'h00000011, 4'b1111, 32'h0,        32'h0};
    vecs[4]  = '{1'b1, 4'd2,  32'h00000012, 4'b1111, 32'h0,        32'h0};
    vecs[5]  = '{1'b1, 4'd3,  32'h00000013, 4'b1111, 32'h0,        32'h0};
    vecs[6]  = '{1'b0, 4'd0,  32'h0,        4'b0000, 32'h00000010, 32'h00000010};
    vecs[7]  = '{1'b0, 4'd1,  32'h0,        4'b0000, 32'h00000011, 32'h00000011};
    vecs[8]  = '{1'b0, 4'd2,  32'h0,        4'b0000, 32'h00000012, 32'h00000012};
    vecs[9]  = '{1'b0, 4'd3,  32'h0,        4'b0000, 32'h00000013, 32'h00000013};
    vecs[10] = '{1'b1, 4'd13, 32'hCAFEF00D, 4'b1111, 32'h0,        32'h0};
    vecs[11] = '{1'b0, 4'd13, 32'h0,        4'b0000, 32'hCAFEF00D, 32'h0};
    vecs[12] = '{1'b0, 4'd1,  32'h0,        4'b0000, 32'h00000011, 32'h00000011};
    vecs[13] = '{1'b1, 4'd5,  32'h12345678, 4'b0000, 32'h0,        32'h0};
    vecs[14] = '{1'b0, 4'd5,  32'h0,        4'b0000, 32'h00AD00EF, 32'h00AD00EF};
    vecs[15] = '{1'b1, 4'd7,  32'hA5A5A5A5, 4'b1010, 32'h0,        32'h0};
    vecs[16] = '{1'b0, 4'd7,  32'h0,        4'b0000, 32'hA500A500, 32'hA500A500};
    vecs[17] = '{1'b1, 4'd12, 32'h11112222, 4'b1111, 32'h0,        32'h0};
    vecs[18] = '{1'b0, 4'd12, 32'h0,        4'b0000, 32'h11112222, 32'h0};
    vecs[19] = '{1'b0, 4'd11, 32'h0,        4'b0000, 32'h0,        32'h0};
    vecs[20] = '{1'b1, 4'd15, 32'hFFFFFFFF, 4'b1000, 32'h0,        32'h0};
    vecs[21] = '{1'b0, 4'd15, 32'h0,        4'b0000, 32'hFF000000, 32'h0};

    tick();
    tick();
    check_reset_outputs("reset");
    reset_n = 1'b1;
    check_clear();
    read_all_zero();

    // Table applied back-to-back, no idle cycles between requests.
    foreach (vecs[v]) begin
      if (vecs[v].wr) begin
        issue(1'b1, 1'b0, vecs[v].addr, vecs[v].data, vecs[v].be);
      end else begin
        do_read(vecs[v].addr, vecs[v].exp16, vecs[v].exp12);
      end
    end
    drain(4);
    check_sb_empty("table");

    // Read and write together: write lands, no readdatavalid.
    issue(1'b1, 1'b1, 4'd4, 32'h00000077, 4'b1111);
    drain(3);
    check_sb_empty("rw_same_cycle");
    do_read(4'd4, 32'h00000077, 32'h00000077);
    drain(3);
    check_sb_empty("rw_readback");

    // Read accepted, then clken low for 3 cycles.
    for (int i = 0; i < NI; i++) begin
      push(i, 32'h00000010, act_cnt + 32'(LAT[i]));
    end
    chipselect = 1'b1; read = 1'b1; address = 4'd0;
    @(posedge clk);
    if (clken) act_cnt++;
    #1;
    chipselect = 1'b0; read = 1'b0; clken = 1'b0;
    @(negedge clk);
    monitor();
    chk("freeze_valid_0", 32'(rdv), 32'd0);
    chk("freeze_waitreq", 32'(wreq), 32'd7);
    for (int k = 1; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      monitor();
      chk($sformatf("freeze_valid_%0d", k), 32'(rdv), 32'd0);
    end
    @(posedge clk);
    #1;
    clken = 1'b1;
    @(negedge clk);
    monitor();
    chk("freeze_release_valid", 32'(rdv), 32'b101);
    drain(3);
    check_sb_empty("freeze");

    // Reset with a read in flight: the result is lost.
    chipselect = 1'b1; read = 1'b1; address = 4'd5;
    @(posedge clk);
    if (clken) act_cnt++;
    #1;
    reset_n = 1'b0; chipselect = 1'b0; read = 1'b0;
    #1;
    check_reset_outputs("rst_pending_read");
    @(negedge clk);
    monitor();
    reset_n = 1'b1;
    drain(7);
    chk("clear_busy_c7", 32'(wreq), 32'd7);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid_clear");
    tick();
    reset_n = 1'b1;
    check_clear();
    read_all_zero();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
